gol_phase_sequencer: RTL and testbench

Parametrised phase sequencer for the cell-array datapath. It sweeps every array position through a write-array / run / write-memory phase triple. It gates `run` so that each generation is exactly one complete sweep, never a partial one. Generations are triggered by a programmable timer, a single-step input, or back-to-back fast mode. It sits between the top level and the cell array and replaces the fixed 4-position, fixed-delay sequencer.

---
 rtl/gol_phase_sequencer.sv | 99 +++++++++
 tb/tb_gol_phase_sequencer.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/gol_phase_sequencer.sv
// rtl/gol_phase_sequencer.sv - write-array/run/write-mem phase sequencer gating whole-sweep generations
module gol_phase_sequencer #(
    parameter int POS_W = 2,
    parameter int DELAY = 100000000,
    parameter int GEN_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       mode,
    input  logic             step,
    output logic [POS_W-1:0] pos,
    output logic             write_array,
    output logic             run,
    output logic             write_mem,
    output logic             busy,
    output logic             gen_done,
    output logic [GEN_W-1:0] gen_count
);

    localparam int               SEQ_W      = POS_W + 2;
    localparam logic [SEQ_W-1:0] SEQ_LAST   = '1;
    localparam logic [SEQ_W-1:0] SEQ_ONE    = SEQ_W'(1);
    localparam logic [GEN_W-1:0] GEN_ONE    = GEN_W'(1);
    localparam logic [31:0]      TIMER_LAST = 32'(DELAY - 1);

    localparam logic [1:0] MODE_PAUSE = 2'b00;
    localparam logic [1:0] MODE_FREE  = 2'b01;
    localparam logic [1:0] MODE_STEP  = 2'b10;
    localparam logic [1:0] MODE_FAST  = 2'b11;

    logic [SEQ_W-1:0] r_seq;
    logic [31:0]      r_timer;
    logic             r_step_d;
    logic             r_pending;
    logic             r_active;
    logic             r_gen_done;
    logic [GEN_W-1:0] r_gen_count;

    logic w_seq_last;
    logic w_tick;
    logic w_step_edge;
    logic w_set;
    logic w_start;
    logic w_sweep_end;

    assign w_seq_last  = (r_seq == SEQ_LAST);
    assign w_tick      = (mode == MODE_FREE) && (r_timer == TIMER_LAST);
    assign w_step_edge = (mode == MODE_STEP) && step && !r_step_d;
    assign w_set       = w_tick || w_step_edge || (mode == MODE_FAST);
    // Sweeps only begin on a seq wrap, so a generation is always a whole sweep.
    assign w_start     = r_pending && w_seq_last;
    assign w_sweep_end = r_active && w_seq_last;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_seq       <= '0;
            r_timer     <= '0;
            r_step_d    <= 1'b0;
            r_pending   <= 1'b0;
            r_active    <= 1'b0;
            r_gen_done  <= 1'b0;
            r_gen_count <= '0;
        end else begin
            r_seq    <= r_seq + SEQ_ONE;
            r_step_d <= step;

            if (mode == MODE_FREE) begin
                r_timer <= w_tick ? 32'd0 : r_timer + 32'd1;
            end else begin
                r_timer <= 32'd0;
            end

            // A new request in the start cycle wins, queueing the next sweep.
            if (mode == MODE_PAUSE) begin
                r_pending <= 1'b0;
            end else begin
                r_pending <= (r_pending && !w_start) || w_set;
            end

            if (w_seq_last) begin
                r_active <= w_start;
            end

            r_gen_done <= w_sweep_end;
            if (w_sweep_end) begin
                r_gen_count <= r_gen_count + GEN_ONE;
            end
        end
    end

    assign pos         = r_seq[SEQ_W-1:2];
    assign write_array = (r_seq[1:0] == 2'b01);
    assign run         = (r_seq[1:0] == 2'b10) && r_active;
    assign write_mem   = (r_seq[1:0] == 2'b11);
    assign busy        = r_pending || r_active;
    assign gen_done    = r_gen_done;
    assign gen_count   = r_gen_count;

endmodule

// File: tb/tb_gol_phase_sequencer.sv
// tb/tb_gol_phase_sequencer.sv - directed and randomized checks against a sweep-schedule model
module tb_gol_phase_sequencer;

    localparam int POS_W = 2;
    localparam int DELAY = 40;
    localparam int GEN_W = 4;
    localparam int NPOS  = 1 << POS_W;
    localparam int S     = 4 * NPOS;

    logic             clk = 1'b0;
    logic             reset_n;
    logic [1:0]       mode;
    logic             step;
    logic [POS_W-1:0] pos;
    logic             write_array;
    logic             run;
    logic             write_mem;
    logic             busy;
    logic             gen_done;
    logic [GEN_W-1:0] gen_count;

    gol_phase_sequencer #(.POS_W(POS_W), .DELAY(DELAY), .GEN_W(GEN_W)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .mode       (mode),
        .step       (step),
        .pos        (pos),
        .write_array(write_array),
        .run        (run),
        .write_mem  (write_mem),
        .busy       (busy),
        .gen_done   (gen_done),
        .gen_count  (gen_count)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    // Model: cycle index since reset, list of scheduled sweep begin cycles.
    int m_c       = 0;
    int m_q[$];
    int m_cur     = -1;
    int m_gen     = 0;
    int m_done_at = -1;
    int m_run01   = 0;
    bit m_prev_step = 1'b0;

    task automatic model_reset();
        m_c         = 0;
        m_q.delete();
        m_cur       = -1;
        m_gen       = 0;
        m_done_at   = -1;
        m_run01     = 0;
        m_prev_step = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, m_c, obs, exp);
    endtask

    task automatic cycle(input logic [1:0] md, input logic st, input logic rn);
        logic [31:0] exp_v;
        logic [31:0] obs_v;
        bit          act;
        bit          tick;
        bit          req;
        int          b;
        mode    = md;
        step    = st;
        reset_n = rn;
        if (m_q.size() > 0 && m_q[0] == m_c) begin
            m_cur = m_c;
            void'(m_q.pop_front());
        end
        act   = (m_cur >= 0) && (m_c >= m_cur) && (m_c < m_cur + S);
        exp_v = {21'd0, 2'((m_c / 4) % NPOS), (m_c % 4 == 1), act && (m_c % 4 == 2),
                 (m_c % 4 == 3), act || (m_q.size() > 0), (m_c == m_done_at), 4'(m_gen)};
        obs_v = {21'd0, pos, write_array, run, write_mem, busy, gen_done, gen_count};
        chk("outputs", obs_v, exp_v);
        if (rn) begin
            if (act && m_c == m_cur + S - 1) begin
                m_gen     = (m_gen + 1) % (1 << GEN_W);
                m_done_at = m_c + 1;
            end
            tick = 1'b0;
            if (md == 2'b01) begin
                m_run01++;
                tick = (m_run01 % DELAY == 0);
            end else begin
                m_run01 = 0;
            end
            req = (md == 2'b01 && tick) || (md == 2'b10 && st && !m_prev_step) || (md == 2'b11);
            m_prev_step = st;
            if (md == 2'b00) begin
                while (m_q.size() > 0 && m_q[m_q.size()-1] > m_c + 1) void'(m_q.pop_back());
            end
            if (req) begin
                b = S * ((m_c + 2 + S - 1) / S);
                if (m_q.size() == 0 || m_q[m_q.size()-1] != b) m_q.push_back(b);
            end
            m_c++;
        end else begin
            model_reset();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run_to(input int target, input logic [1:0] md, input logic st);
        while (m_c < target) cycle(md, st, 1'b1);
    endtask

    initial begin
        logic [1:0] r_md;
        logic       r_st;
        int         len;
        reset_n = 1'b0;
        mode    = 2'b11;
        step    = 1'b1;
        @(posedge clk);
        #1;
        model_reset();
        chk("reset_outs", 32'({pos, write_array, run, write_mem, busy, gen_done, gen_count}), 32'd0);
        cycle(2'b11, 1'b1, 1'b0);
        cycle(2'b11, 1'b1, 1'b0);

        run_to(1, 2'b00, 1'b0);
        chk("pause_wa_c1", 32'(write_array), 32'd1);
        run_to(3, 2'b00, 1'b0);
        chk("pause_wm_c3", 32'(write_mem), 32'd1);
        run_to(20, 2'b00, 1'b0);

        cycle(2'b00, 1'b0, 1'b0);
        run_to(39, 2'b01, 1'b0);
        chk("free_busy_c39", 32'(busy), 32'd0);
        run_to(40, 2'b01, 1'b0);
        chk("free_busy_c40", 32'(busy), 32'd1);
        run_to(50, 2'b01, 1'b0);
        chk("free_run_c50", 32'({run, pos}), 32'({1'b1, 2'd0}));
        run_to(62, 2'b01, 1'b0);
        chk("free_run_c62", 32'({run, pos}), 32'({1'b1, 2'd3}));
        run_to(64, 2'b01, 1'b0);
        chk("free_done_c64", 32'({gen_done, gen_count}), 32'({1'b1, 4'd1}));
        run_to(98, 2'b01, 1'b0);
        chk("free_run_c98", 32'(run), 32'd1);

        cycle(2'b00, 1'b0, 1'b0);
        run_to(18, 2'b11, 1'b0);
        chk("fast_run_c18", 32'(run), 32'd1);
        run_to(32, 2'b11, 1'b0);
        chk("fast_done_c32", 32'(gen_done), 32'd1);
        run_to(48, 2'b11, 1'b0);
        chk("fast_done_c48", 32'(gen_done), 32'd1);
        run_to(64, 2'b11, 1'b0);
        chk("fast_done_c64", 32'({gen_done, gen_count}), 32'({1'b1, 4'd3}));

        cycle(2'b00, 1'b0, 1'b0);
        run_to(5, 2'b10, 1'b0);
        run_to(10, 2'b10, 1'b1);
        run_to(18, 2'b10, 1'b0);
        chk("step_run_c18", 32'(run), 32'd1);
        run_to(20, 2'b10, 1'b0);
        run_to(22, 2'b10, 1'b1);
        run_to(24, 2'b10, 1'b0);
        run_to(25, 2'b10, 1'b1);
        run_to(32, 2'b10, 1'b0);
        chk("step_done_c32", 32'({gen_done, gen_count}), 32'({1'b1, 4'd1}));
        run_to(34, 2'b10, 1'b0);
        chk("step_run_c34", 32'(run), 32'd1);
        run_to(48, 2'b10, 1'b0);
        chk("step_done_c48", 32'({gen_done, gen_count, busy}), 32'({1'b1, 4'd2, 1'b0}));
        run_to(70, 2'b10, 1'b0);
        chk("step_idle_c70", 32'({gen_count, busy}), 32'({4'd2, 1'b0}));

        cycle(2'b00, 1'b0, 1'b0);
        run_to(52, 2'b01, 1'b0);
        run_to(54, 2'b00, 1'b0);
        chk("pause_mid_run_c54", 32'(run), 32'd1);
        run_to(62, 2'b00, 1'b0);
        chk("pause_mid_run_c62", 32'(run), 32'd1);
        run_to(64, 2'b00, 1'b0);
        chk("pause_mid_done_c64", 32'(gen_done), 32'd1);
        run_to(90, 2'b00, 1'b0);
        chk("pause_mid_idle", 32'({gen_count, busy}), 32'({4'd1, 1'b0}));
        chk("pause_timer", dut.r_timer, 32'd0);

        cycle(2'b00, 1'b0, 1'b0);
        run_to(55, 2'b01, 1'b0);
        cycle(2'b01, 1'b0, 1'b0);
        chk("abort_c56", 32'({run, gen_count, busy, gen_done}), 32'd0);
        run_to(30, 2'b01, 1'b0);

        r_st = 1'b0;
        for (int seg = 0; seg < 40; seg++) begin
            r_md = 2'($urandom_range(0, 3));
            len  = $urandom_range(5, 120);
            for (int i = 0; i < len; i++) begin
                if ($urandom_range(0, 3) == 0) r_st = ~r_st;
                cycle(r_md, r_st, ($urandom_range(0, 199) != 0));
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
